// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out shift register.
//   PISO_WIDTH_DEF : default parallel word width
//   MODE_LOAD      : w_piso value that loads d into the register
//   MODE_SHIFT     : w_piso value that shifts the register right by one
//   cnt_w()        : width of a counter able to hold 0..width inclusive
package piso_pkg;

    localparam int unsigned PISO_WIDTH_DEF = 4;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_shift_counter.sv
// Counts shifts since the last load/reset, saturating at WIDTH, and flags
// when a whole word has been shifted out.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   load  : parallel load this edge, clears the count
//   shift : shift this edge, increments the count (saturating)
//   done  : high while count == WIDTH
module piso_shift_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    output logic done
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (shift && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out shift register. Loads a WIDTH-bit word when
// w_piso=0 and shifts it out LSB-first on q while w_piso=1, zero filling.
// Optional feature macro: PISO_DONE_EN adds the done output (word fully
// shifted out).
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous active-high reset, clears the register
//   w_piso : 0 = parallel load, 1 = shift
//   d      : parallel load data, sampled only when w_piso=0
//   q      : serial output, register bit 0 (combinational)
//   done   : (PISO_DONE_EN only) WIDTH shifts since last load/reset
module shift_register_piso
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_piso,
    input  logic [WIDTH-1:0] d,
`ifdef PISO_DONE_EN
    output logic             q,
    output logic             done
`else
    output logic             q
`endif
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority over shift; rst is handled in the register itself.
    always_comb begin
        sr_d = sr_q;
        if (w_piso == MODE_LOAD) begin
            sr_d = d;
        end else begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[0];

`ifdef PISO_DONE_EN
    piso_shift_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (w_piso == MODE_LOAD),
        .shift (w_piso == MODE_SHIFT),
        .done  (done)
    );
`endif

endmodule

// File: tb/tb_shift_register_piso.sv
// Scoreboard bench for shift_register_piso: WIDTH=4 and WIDTH=8 instances.
// Stimulus pushes the expected post-edge q (and done) into a queue; a
// monitor pops and compares on each falling edge.
module tb_shift_register_piso;

    typedef struct packed {
        logic q;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst4, w4, rst8, w8;
    logic [3:0] d4;
    logic [7:0] d8;
    logic       q4, q8;
    logic       done4, done8;

    exp_t exp4[$];
    exp_t exp8[$];

    int errors = 0;
    int checks = 0;

    always #4 clk = ~clk;

    shift_register_piso #(
        .WIDTH (4)
    ) dut4 (
        .clk    (clk),
        .rst    (rst4),
        .w_piso (w4),
        .d      (d4),
`ifdef PISO_DONE_EN
        .q      (q4),
        .done   (done4)
`else
        .q      (q4)
`endif
    );

    shift_register_piso #(
        .WIDTH (8)
    ) dut8 (
        .clk    (clk),
        .rst    (rst8),
        .w_piso (w8),
        .d      (d8),
`ifdef PISO_DONE_EN
        .q      (q8),
        .done   (done8)
`else
        .q      (q8)
`endif
    );

`ifndef PISO_DONE_EN
    assign done4 = 1'b0;
    assign done8 = 1'b0;
`endif

    // Monitor: compares whatever the stimulus predicted for the last edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp4.size() > 0) begin
            e = exp4.pop_front();
            checks++;
            if (q4 !== e.q) begin
                errors++;
                $display("FAIL w4_q @%0t: got %b expected %b", $time, q4, e.q);
            end
`ifdef PISO_DONE_EN
            checks++;
            if (done4 !== e.done) begin
                errors++;
                $display("FAIL w4_done @%0t: got %b expected %b", $time, done4, e.done);
            end
`endif
        end
        if (exp8.size() > 0) begin
            e = exp8.pop_front();
            checks++;
            if (q8 !== e.q) begin
                errors++;
                $display("FAIL w8_q @%0t: got %b expected %b", $time, q8, e.q);
            end
`ifdef PISO_DONE_EN
            checks++;
            if (done8 !== e.done) begin
                errors++;
                $display("FAIL w8_done @%0t: got %b expected %b", $time, done8, e.done);
            end
`endif
        end
    end

    // Called just after a falling edge: drive, take the edge, record expectation.
    task automatic step4(input logic r, input logic w, input logic [3:0] dv,
                         input logic eq, input logic ed);
        exp_t e;
        rst4 = r;
        w4   = w;
        d4   = dv;
        @(posedge clk);
        e.q    = eq;
        e.done = ed;
        exp4.push_back(e);
        @(negedge clk);
    endtask

    task automatic step8(input logic r, input logic w, input logic [7:0] dv,
                         input logic eq, input logic ed);
        exp_t e;
        rst8 = r;
        w8   = w;
        d8   = dv;
        @(posedge clk);
        e.q    = eq;
        e.done = ed;
        exp8.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        rst4 = 1'b1; w4 = 1'b0; d4 = 4'h0;
        rst8 = 1'b1; w8 = 1'b0; d8 = 8'h00;
        @(negedge clk);

        // 1: reset wins over load
        step4(1, 0, 4'b1010, 0, 0);
        // 2: load 1010, shift out 0,1,0,1 then drained
        step4(0, 0, 4'b1010, 0, 0);
        step4(0, 1, 4'b1010, 1, 0);
        step4(0, 1, 4'b1010, 0, 0);
        step4(0, 1, 4'b1010, 1, 0);
        step4(0, 1, 4'b1010, 0, 1);
        step4(0, 1, 4'b1010, 0, 1);  // shift past width: stays 0, done saturates
        // 3: load 1100 -> 0,0,1,1,0
        step4(0, 0, 4'b1100, 0, 0);
        step4(0, 1, 4'b0000, 0, 0);
        step4(0, 1, 4'b0000, 1, 0);
        step4(0, 1, 4'b0000, 1, 0);
        step4(0, 1, 4'b0000, 0, 1);
        // 4: load 1111, shift 2, reload 0001 mid-shift
        step4(0, 0, 4'b1111, 1, 0);
        step4(0, 1, 4'b0000, 1, 0);
        step4(0, 1, 4'b0000, 1, 0);
        step4(0, 0, 4'b0001, 1, 0);
        step4(0, 1, 4'b0000, 0, 0);
        step4(0, 1, 4'b0000, 0, 0);
        step4(0, 1, 4'b0000, 0, 0);
        step4(0, 1, 4'b0000, 0, 1);
        // 5: load 1011, shift 1, reset mid-shift
        step4(0, 0, 4'b1011, 1, 0);
        step4(0, 1, 4'b0000, 1, 0);
        step4(1, 1, 4'b0000, 0, 0);
        step4(0, 1, 4'b1111, 0, 0);
        step4(0, 1, 4'b1111, 0, 0);
        // Held load reloads every edge, q follows d[0]
        step4(0, 0, 4'b0001, 1, 0);
        step4(0, 0, 4'b0010, 0, 0);
        step4(0, 0, 4'b0011, 1, 0);

        // 6: WIDTH=8, A5 -> 1,0,1,0,0,1,0,1 then 0 with done
        step8(1, 0, 8'hFF, 0, 0);
        step8(0, 0, 8'hA5, 1, 0);
        step8(0, 1, 8'h00, 0, 0);
        step8(0, 1, 8'h00, 1, 0);
        step8(0, 1, 8'h00, 0, 0);
        step8(0, 1, 8'h00, 0, 0);
        step8(0, 1, 8'h00, 1, 0);
        step8(0, 1, 8'h00, 0, 0);
        step8(0, 1, 8'h00, 1, 0);
        step8(0, 1, 8'h00, 0, 1);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && (exp4.size() + exp8.size()) > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if ((exp4.size() + exp8.size()) > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp4.size() + exp8.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
